// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer.
//   - FSM state encoding (IDLE/LO/HI/DONE)
//   - bit positions inside the {CMP,V,C,N,Z} flag register
//   - control codes (cins) of the ALU ROM used by the decoder and the bench
package alu_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int FLAG_Z   = 0;
  localparam int FLAG_N   = 1;
  localparam int FLAG_C   = 2;
  localparam int FLAG_V   = 3;
  localparam int FLAG_CMP = 4;

  localparam logic [7:0] ALU_ADD = 8'h00;
  localparam logic [7:0] ALU_ADC = 8'h01;
  localparam logic [7:0] ALU_SUB = 8'h02;
  localparam logic [7:0] ALU_CMP = 8'h03;

endpackage

// File: rtl/alu_sequencer_flags.sv
// Persistent flag register {CMP,V,C,N,Z} of the ALU sequencer.
// Ports:
//   clk_i, rst_ni  clock / asynchronous active-low reset (to FLAGS_RST)
//   we_i           write strobe, asserted on the edge that completes an op
//   wide_i         completing op is 16-bit (Z covers both bytes, N from hi)
//   lo_i, hi_i     result bytes of the completing op (hi_i = 0 when narrow)
//   c_i, v_i, cmp_i  carryout / overout / cmpo of the final ALU pass
//   flags_o        registered flags
module alu_sequencer_flags
  import alu_sequencer_pkg::*;
#(
  parameter logic [4:0] FLAGS_RST = 5'b00000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       we_i,
  input  logic       wide_i,
  input  logic [7:0] lo_i,
  input  logic [7:0] hi_i,
  input  logic       c_i,
  input  logic       v_i,
  input  logic       cmp_i,
  output logic [4:0] flags_o
);

  logic [4:0] flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (we_i) begin
      flags_d[FLAG_Z]   = wide_i ? ({hi_i, lo_i} == 16'h0000) : (lo_i == 8'h00);
      flags_d[FLAG_N]   = wide_i ? hi_i[7] : lo_i[7];
      flags_d[FLAG_C]   = c_i;
      flags_d[FLAG_V]   = v_i;
      flags_d[FLAG_CMP] = cmp_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) flags_q <= FLAGS_RST;
    else         flags_q <= flags_d;
  end

  assign flags_o = flags_q;

endmodule

// File: rtl/alu_sequencer.sv
// ALU sequencer: initiator between the instruction decoder and a
// combinational 8-bit ALU. Narrow ops take one ALU pass, wide (16-bit) ops
// take two chained passes (low byte, then high byte with the low carry).
// Ports:
//   clk, rst_n                      clock / asynchronous active-low reset
//   req_*                           operation request (valid/ready)
//   rsp_valid/rsp_ready/rsp_result  result handshake, held until taken
//   flags                           {CMP,V,C,N,Z} flag register
//   alu_a/b/cins/oe/carryin         drive to the ALU
//   alu_aluout/carryout/overout/cmpo  ALU results
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter bit         WIDE_EN   = 1'b1,
  parameter logic [4:0] FLAGS_RST = 5'b00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cins,
  input  logic        req_wide,
  input  logic        req_use_carry,
  input  logic        req_setflags,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [4:0]  flags,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [7:0]  alu_cins,
  output logic        alu_oe,
  output logic        alu_carryin,
  input  logic [7:0]  alu_aluout,
  input  logic        alu_carryout,
  input  logic        alu_overout,
  input  logic        alu_cmpo
);

  state_e      state_q, state_d;
  logic [7:0]  cins_q;
  logic        wide_q, use_carry_q, setflags_q;
  logic [15:0] a_q, b_q;
  logic [7:0]  res_lo_q, res_hi_q;
  logic        c_lo_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_valid) state_d = ST_LO;
      ST_LO:   state_d = wide_q ? ST_HI : ST_DONE;
      ST_HI:   state_d = ST_DONE;
      ST_DONE: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: the ALU is only enabled during the two pass states
  always_comb begin
    req_ready   = (state_q == ST_IDLE);
    rsp_valid   = (state_q == ST_DONE);
    rsp_result  = {res_hi_q, res_lo_q};
    alu_a       = 8'h00;
    alu_b       = 8'h00;
    alu_cins    = 8'h00;
    alu_oe      = 1'b0;
    alu_carryin = 1'b0;
    unique case (state_q)
      ST_LO: begin
        alu_a       = a_q[7:0];
        alu_b       = b_q[7:0];
        alu_cins    = cins_q;
        alu_oe      = 1'b1;
        alu_carryin = use_carry_q & flags[FLAG_C];
      end
      ST_HI: begin
        alu_a       = a_q[15:8];
        alu_b       = b_q[15:8];
        alu_cins    = cins_q;
        alu_oe      = 1'b1;
        alu_carryin = c_lo_q;
      end
      default: ;
    endcase
  end

  // Operand latch and per-pass result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cins_q      <= 8'h00;
      wide_q      <= 1'b0;
      use_carry_q <= 1'b0;
      setflags_q  <= 1'b0;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      res_lo_q    <= 8'h00;
      res_hi_q    <= 8'h00;
      c_lo_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (req_valid) begin
          cins_q      <= req_cins;
          wide_q      <= WIDE_EN & req_wide;
          use_carry_q <= req_use_carry;
          setflags_q  <= req_setflags;
          a_q         <= req_a;
          b_q         <= req_b;
        end
        ST_LO: begin
          res_lo_q <= alu_aluout;
          c_lo_q   <= alu_carryout;
          // Narrow results must read back with a zero high byte.
          res_hi_q <= 8'h00;
        end
        ST_HI: res_hi_q <= alu_aluout;
        default: ;
      endcase
    end
  end

  // Flags are written on the edge that leaves the final pass. In HI the
  // low byte comes from the register captured during LO.
  logic       flag_we, flag_wide;
  logic [7:0] flag_lo, flag_hi;

  assign flag_wide = (state_q == ST_HI);
  assign flag_we   = setflags_q &
                     (flag_wide | ((state_q == ST_LO) & ~wide_q));
  assign flag_lo   = flag_wide ? res_lo_q : alu_aluout;
  assign flag_hi   = flag_wide ? alu_aluout : 8'h00;

  alu_sequencer_flags #(
    .FLAGS_RST(FLAGS_RST)
  ) u_flags (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (flag_we),
    .wide_i  (flag_wide),
    .lo_i    (flag_lo),
    .hi_i    (flag_hi),
    .c_i     (alu_carryout),
    .v_i     (alu_overout),
    .cmp_i   (alu_cmpo),
    .flags_o (flags)
  );

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Initiator side of the ALU interface: accepts an ALU operation request from the CPU control path and drives the ALU inputs (operands, cins, oe, carryin).
- Captures aluout, carryout, overout and cmpo, and holds the result and a persistent flag register.
- Runs 8-bit operations in one ALU pass and 16-bit operations in two chained passes (low byte, then high byte with carry).
- Sits between the instruction decoder and the combinational ALU.

Parameters:
- WIDE_EN, 1, when 0 the req_wide input is ignored and every operation is a single pass.
- FLAGS_RST, 5'b00000, reset value of the flag register {CMP,V,C,N,Z}.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  operation request.
- req_ready  out  1  sequencer can accept a request.
- req_cins  in  8  ALU control code (ROM index).
- req_wide  in  1  16-bit operation, two passes.
- req_use_carry  in  1  first pass carryin = flag C (else 0).
- req_setflags  in  1  update the flag register on completion.
- req_a  in  16  operand A ({hi,lo}; hi is ignored when narrow).
- req_b  in  16  operand B.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_result  out  16  result (hi = 0 for narrow operations).
- flags  out  5  {CMP,V,C,N,Z} register.
- alu_a  out  8  to ALU a.
- alu_b  out  8  to ALU b.
- alu_cins  out  8  to ALU cins.
- alu_oe  out  1  to ALU oe.
- alu_carryin  out  1  to ALU carryin.
- alu_aluout  in  8  from ALU.
- alu_carryout  in  1  from ALU.
- alu_overout  in  1  from ALU.
- alu_cmpo  in  1  from ALU.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - req_ready=1, rsp_valid=0, rsp_result=0, flags=FLAGS_RST.
  - All alu_* outputs 0, including alu_oe=0.
  - Latched operands and control cleared.
  - Reset mid-operation abandons the operation; no flag update occurs.
- States:
  - IDLE: req_ready=1. A cycle with req_valid=1 latches cins, wide, use_carry, setflags, a and b, then goes to LO.
  - LO (1 cycle):
    - Drives alu_a=a[7:0], alu_b=b[7:0], alu_cins=cins, alu_oe=1.
    - alu_carryin = use_carry ? flags.C : 0.
    - On the clock edge, captures aluout into res_lo and carryout into c_lo.
    - Goes to HI if the operation is wide and WIDE_EN=1, else to DONE.
  - HI (1 cycle):
    - Drives alu_a=a[15:8], alu_b=b[15:8], alu_cins=cins, alu_oe=1, alu_carryin=c_lo.
    - Captures aluout into res_hi, then goes to DONE.
  - DONE:
    - rsp_valid=1, rsp_result={res_hi,res_lo}, held stable until rsp_ready=1.
    - Goes to IDLE on the cycle where rsp_ready=1.
- ALU drive outside LO/HI:
  - In IDLE and DONE, alu_oe=0; alu_a, alu_b, alu_cins and alu_carryin are driven 0.
- Ready and throughput:
  - req_ready=1 only in IDLE. No accept in the DONE->IDLE cycle.
  - Throughput: narrow 3 cycles per op, wide 4 cycles per op.
- Flag update: written on the LO->DONE or HI->DONE edge when setflags=1; unchanged otherwise.
  - Z: narrow res==0; wide {hi,lo}==0.
  - N: msb of the final pass aluout.
  - C: carryout of the final pass.
  - V: overout of the final pass.
  - CMP: cmpo of the final pass.
  - The flags output shows the new values in the same cycle rsp_valid first asserts.
- Flag read timing: use_carry reads flags.C as registered at LO; a completed op's flags are visible to the next request.
- Width: req_a/req_b hi bytes are ignored for narrow ops; res_hi is forced 0 for narrow ops.

Decomposition:
- Shared include alu_defs.vh:
  - State encodings IDLE=2'd0, LO=2'd1, HI=2'd2, DONE=2'd3.
  - Flag bit indices FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3, FLAG_CMP=4.
  - Named cins constants ALU_ADD, ALU_ADC, ALU_SUB, ALU_CMP matching the ALU ROM.
- One sub-module: alu_flags, the flag register with write enable, Z/N derivation and async reset to FLAGS_RST.

Test Plan:
Bench instantiates the real ALU with its ROM and uses the alu_defs.vh constants.
1. Narrow ALU_ADD, a=0x7F, b=0x01, setflags=1 -> rsp 0x0080 three cycles after accept; N=1, V=1, Z=0, C=0.
2. Narrow ALU_ADD, a=0xFF, b=0x01 -> rsp 0x0000, Z=1, C=1; then ALU_ADC use_carry=1, a=0x10, b=0x20 -> rsp 0x0031 and alu_carryin=1 during LO.
3. Wide ALU_ADD, a=0x00FF, b=0x0001 -> alu_carryin=1 in HI, rsp 0x0100 at cycle 4, Z=0, C=0.
4. Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_result stable, req_ready=0, alu_oe=0; release -> IDLE next cycle.
5. setflags=0 op after test 2 -> flags unchanged while the result is still returned.
6. rst_n pulsed low during HI -> immediately req_ready=1, rsp_valid=0, alu_oe=0, flags=FLAGS_RST; the next request completes normally.
